// File: rtl/word_splitter.sv
// word_splitter: width-down converter. Takes one BEATS*DATA_WIDTH word per
// input handshake and replays it as BEATS DATA_WIDTH beats downstream, with
// no bubble between words when both sides run at full rate.
module word_splitter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BEATS      = 4,
    parameter bit          LSB_FIRST  = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_WIDTH*BEATS-1:0] i_data_in,
    input  logic                        i_valid_a,
    output logic                        o_ready_a,
    output logic [DATA_WIDTH-1:0]       o_data_out,
    output logic                        o_valid_b,
    output logic                        o_last_b,
    input  logic                        i_ready_b
);

    localparam int unsigned     CntW    = $clog2(BEATS);
    localparam logic [CntW-1:0] LastCnt = CntW'(BEATS - 1);

    logic [DATA_WIDTH*BEATS-1:0] r_word;
    logic [CntW-1:0]             r_cnt;
    logic                        r_valid_b;

    logic                  w_last;
    logic                  w_in_hs;
    logic                  w_out_hs;
    logic [DATA_WIDTH-1:0] w_beat;

    assign w_last   = (r_cnt == LastCnt);
    // ready_b feeds ready_a combinationally so a new word can load on the
    // final-beat handshake without a bubble.
    assign o_ready_a = ~r_valid_b | (i_ready_b & w_last);
    assign w_in_hs   = i_valid_a & o_ready_a;
    assign w_out_hs  = r_valid_b & i_ready_b;

    // Select the current beat slice from the held word.
    always_comb begin
        w_beat = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (r_cnt == CntW'(i)) begin
                if (LSB_FIRST) begin
                    w_beat = r_word[i*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    w_beat = r_word[(BEATS-1-i)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Load on input handshake, step the beat index on output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word    <= '0;
            r_cnt     <= '0;
            r_valid_b <= 1'b0;
        end else if (w_in_hs) begin
            // Covers both idle load and final-beat overlap (valid stays high).
            r_word    <= i_data_in;
            r_cnt     <= '0;
            r_valid_b <= 1'b1;
        end else if (w_out_hs) begin
            if (w_last) begin
                r_cnt     <= '0;
                r_valid_b <= 1'b0;
            end else begin
                r_cnt <= r_cnt + CntW'(1);
            end
        end
    end

    assign o_data_out = w_beat;
    assign o_valid_b  = r_valid_b;
    assign o_last_b   = r_valid_b & w_last;

endmodule

// File: tb/tb_word_splitter.sv
// Directed bench for word_splitter: one LSB-first and one MSB-first instance
// share the same stimulus.
module tb_word_splitter;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_in;
    logic        valid_a;
    logic        ready_b;

    logic       ready_a,  valid_b,  last_b;
    logic [7:0] data_out;
    logic       m_ready_a, m_valid_b, m_last_b;
    logic [7:0] m_data_out;

    int vectors;
    int errors;

    word_splitter #(.DATA_WIDTH(8), .BEATS(4), .LSB_FIRST(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_data_in  (data_in),
        .i_valid_a  (valid_a),
        .o_ready_a  (ready_a),
        .o_data_out (data_out),
        .o_valid_b  (valid_b),
        .o_last_b   (last_b),
        .i_ready_b  (ready_b)
    );

    word_splitter #(.DATA_WIDTH(8), .BEATS(4), .LSB_FIRST(1'b0)) dut_m (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_data_in  (data_in),
        .i_valid_a  (valid_a),
        .o_ready_a  (m_ready_a),
        .o_data_out (m_data_out),
        .o_valid_b  (m_valid_b),
        .o_last_b   (m_last_b),
        .i_ready_b  (ready_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the LSB-first beat outputs in one go.
    task automatic beat(input string tag, input logic v, input logic [7:0] d, input logic l);
        chk({tag, ".valid"}, {31'd0, valid_b}, {31'd0, v});
        chk({tag, ".data"},  {24'd0, data_out}, {24'd0, d});
        chk({tag, ".last"},  {31'd0, last_b}, {31'd0, l});
    endtask

    logic [7:0] exp8 [8];

    initial begin
        vectors = 0;
        errors  = 0;
        rst_n   = 1'b0;
        data_in = '0;
        valid_a = 1'b0;
        ready_b = 1'b1;

        // Reset state
        #1;
        beat("rst", 1'b0, 8'h00, 1'b0);
        chk("rst.m_data", {24'd0, m_data_out}, 32'h0);
        chk("rst.m_valid", {31'd0, m_valid_b}, 32'h0);
        #13;
        rst_n = 1'b1;
        tick();
        chk("idle.ready_a", {31'd0, ready_a}, 32'h1);

        // Single word, both orders
        data_in = 32'h44332211;
        valid_a = 1'b1;
        #1;
        chk("t1.ready_a0", {31'd0, ready_a}, 32'h1);
        tick();
        valid_a = 1'b0;
        data_in = 32'hDEADBEEF;
        #1;
        beat("t1.c1", 1'b1, 8'h11, 1'b0);
        chk("t1.c1.ready_a", {31'd0, ready_a}, 32'h0);
        chk("t1.c1.m_data", {24'd0, m_data_out}, 32'h44);
        tick();
        beat("t1.c2", 1'b1, 8'h22, 1'b0);
        chk("t1.c2.ready_a", {31'd0, ready_a}, 32'h0);
        chk("t1.c2.m_data", {24'd0, m_data_out}, 32'h33);
        tick();
        beat("t1.c3", 1'b1, 8'h33, 1'b0);
        chk("t1.c3.ready_a", {31'd0, ready_a}, 32'h0);
        chk("t1.c3.m_data", {24'd0, m_data_out}, 32'h22);
        tick();
        beat("t1.c4", 1'b1, 8'h44, 1'b1);
        chk("t1.c4.ready_a", {31'd0, ready_a}, 32'h1);
        chk("t1.c4.m_data", {24'd0, m_data_out}, 32'h11);
        chk("t1.c4.m_last", {31'd0, m_last_b}, 32'h1);
        tick();
        beat("t1.c5", 1'b0, 8'h11, 1'b0);
        chk("t1.c5.m_valid", {31'd0, m_valid_b}, 32'h0);

        // Back-to-back words at full rate
        exp8[0] = 8'h11; exp8[1] = 8'h22; exp8[2] = 8'h33; exp8[3] = 8'h44;
        exp8[4] = 8'h55; exp8[5] = 8'h66; exp8[6] = 8'h77; exp8[7] = 8'h88;
        data_in = 32'h44332211;
        valid_a = 1'b1;
        tick();
        data_in = 32'h88776655;
        for (int i = 0; i < 8; i++) begin
            #1;
            beat($sformatf("t2.b%0d", i), 1'b1, exp8[i], (i == 3) || (i == 7));
            if (i == 3) chk("t2.ready_a", {31'd0, ready_a}, 32'h1);
            if (i == 4) valid_a = 1'b0;
            @(posedge clk);
        end
        #1;
        beat("t2.end", 1'b0, 8'h55, 1'b0);

        // Backpressure on beat 1; input offered during stall is ignored
        data_in = 32'hDDCCBBAA;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        beat("t3.b0", 1'b1, 8'hAA, 1'b0);
        tick();
        ready_b = 1'b0;
        data_in = 32'h12345678;
        valid_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            beat($sformatf("t3.hold%0d", i), 1'b1, 8'hBB, 1'b0);
            chk($sformatf("t3.hold%0d.ready_a", i), {31'd0, ready_a}, 32'h0);
            tick();
        end
        valid_a = 1'b0;
        ready_b = 1'b1;
        #1;
        beat("t3.b1", 1'b1, 8'hBB, 1'b0);
        tick();
        beat("t3.b2", 1'b1, 8'hCC, 1'b0);
        tick();
        beat("t3.b3", 1'b1, 8'hDD, 1'b1);
        tick();
        beat("t3.end", 1'b0, 8'hAA, 1'b0);

        // Stall on final beat with next word waiting
        data_in = 32'h44332211;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        tick();
        tick();
        tick();
        beat("t4.b3", 1'b1, 8'h44, 1'b1);
        ready_b = 1'b0;
        data_in = 32'h88776655;
        valid_a = 1'b1;
        #1;
        chk("t4.stall.ready_a", {31'd0, ready_a}, 32'h0);
        tick();
        beat("t4.hold", 1'b1, 8'h44, 1'b1);
        chk("t4.hold.ready_a", {31'd0, ready_a}, 32'h0);
        ready_b = 1'b1;
        #1;
        chk("t4.release.ready_a", {31'd0, ready_a}, 32'h1);
        tick();
        valid_a = 1'b0;
        beat("t4.n0", 1'b1, 8'h55, 1'b0);
        tick();
        beat("t4.n1", 1'b1, 8'h66, 1'b0);
        tick();
        beat("t4.n2", 1'b1, 8'h77, 1'b0);
        tick();
        beat("t4.n3", 1'b1, 8'h88, 1'b1);
        tick();
        beat("t4.end", 1'b0, 8'h55, 1'b0);

        // Asynchronous reset mid-word
        data_in = 32'h44332211;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        tick();
        beat("t5.b1", 1'b1, 8'h22, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        beat("t5.rst", 1'b0, 8'h00, 1'b0);
        chk("t5.rst.m_data", {24'd0, m_data_out}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        beat("t5.idle", 1'b0, 8'h00, 1'b0);
        data_in = 32'h88776655;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        beat("t5.n0", 1'b1, 8'h55, 1'b0);
        chk("t5.n0.m_data", {24'd0, m_data_out}, 32'h88);
        tick();
        beat("t5.n1", 1'b1, 8'h66, 1'b0);
        tick();
        tick();
        beat("t5.n3", 1'b1, 8'h88, 1'b1);
        chk("t5.n3.m_data", {24'd0, m_data_out}, 32'h55);
        chk("t5.n3.m_last", {31'd0, m_last_b}, 32'h1);
        tick();
        beat("t5.end", 1'b0, 8'h55, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
